instmem_loader: RTL and testbench

- Write-side companion to the 256x9 instruction memory, which the fetch path reads synchronously by PC.
- Accepts a byte stream over a valid/ready handshake and packs each pair of bytes into one 9-bit instruction.
- Drives the memory's write port with one write per instruction, then flags done or error.
- Sits between the host/UART byte source and the instruction memory; used before the core leaves reset.

---
 rtl/instmem_pkg.sv | 24 ++
 rtl/instmem_loader_pack.sv | 58 +++++
 rtl/instmem_loader.sv | 186 ++++++++++++++++++
 tb/tb_instmem_loader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instmem_pkg.sv
// Shared definitions for the 256x9 instruction memory and its companions
// (loader, fetch path).
//
// Contents:
//   INSTMEM_ADDR_W  - instruction memory address width (depth = 2**ADDR_W)
//   INSTMEM_INST_W  - instruction width, fixed at 9 by the ISA
//   loader_state_t  - loader FSM states; CSUM is only reachable when the
//                     loader is built with INSTMEM_LOADER_CSUM_EN
package instmem_pkg;

  localparam int INSTMEM_ADDR_W = 8;
  localparam int INSTMEM_INST_W = 9;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } loader_state_t;

endpackage

// File: rtl/instmem_loader_pack.sv
// Packs a low/high byte pair into one 9-bit instruction and produces the
// registered memory write strobe and data.
//
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   lo_load     - a LO byte is being accepted this cycle
//   hi_load     - a HI byte is being accepted this cycle
//   in_data     - the stream byte
//   hi_bad      - combinational: HI byte has nonzero bits 7:1
//   we          - registered write strobe, high one cycle after a good HI byte
//   wdata       - registered instruction {hi[0], lo}
module instmem_loader_pack
  import instmem_pkg::*;
#(
  parameter int INST_W = INSTMEM_INST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lo_load,
  input  logic              hi_load,
  input  logic [7:0]        in_data,
  output logic              hi_bad,
  output logic              we,
  output logic [INST_W-1:0] wdata
);

  logic [7:0]        lo_reg;
  logic              we_reg;
  logic [INST_W-1:0] wdata_reg;
  logic [6:0]        pad_bits;

  // Only bit 0 of the HI byte carries data; every other bit must be zero.
  for (genvar gi = 1; gi < 8; gi++) begin : g_pad
    assign pad_bits[gi-1] = in_data[gi];
  end
  assign hi_bad = |pad_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_reg    <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
    end else begin
      if (lo_load) begin
        lo_reg <= in_data;
      end
      // A rejected HI byte never produces a strobe.
      we_reg <= hi_load && !hi_bad;
      if (hi_load && !hi_bad) begin
        wdata_reg <= INST_W'({in_data[0], lo_reg});
      end
    end
  end

  assign we    = we_reg;
  assign wdata = wdata_reg;

endmodule

// File: rtl/instmem_loader.sv
// Instruction memory loader: accepts a byte stream (length byte, then
// LO/HI byte pairs) over valid/ready and writes one 9-bit instruction per
// pair into the instruction memory, starting at BASE_ADDR.
//
// Optional feature: define INSTMEM_LOADER_CSUM_EN to expect a trailing
// checksum byte (8-bit sum of the length byte and all payload bytes).
//
// Ports:
//   clk, rst_n         - clock, synchronous active-low reset
//   start              - one-cycle pulse arming a load (ignored while busy)
//   in_data, in_valid  - stream byte and its valid
//   in_ready           - a byte can be accepted this cycle (from state only)
//   mem_we, mem_addr,
//   mem_wdata          - registered memory write port
//   busy               - load in progress
//   done, err          - sticky completion / format error flags
//   count              - instructions written in the current load
module instmem_loader
  import instmem_pkg::*;
#(
  parameter int                  ADDR_W    = INSTMEM_ADDR_W,
  parameter int                  INST_W    = INSTMEM_INST_W,
  parameter logic [ADDR_W-1:0]   BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  loader_state_t     state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W:0]   n_reg;
  logic              busy_reg;
  logic              done_reg;
  logic              err_reg;
  logic              xfer;
  logic              hi_bad;
`ifdef INSTMEM_LOADER_CSUM_EN
  logic [7:0]        sum_reg;
`endif

  always_comb begin
    in_ready = 1'b0;
    case (state_reg)
      LEN, LO, HI: in_ready = 1'b1;
`ifdef INSTMEM_LOADER_CSUM_EN
      CSUM:        in_ready = 1'b1;
`endif
      default:     in_ready = 1'b0;
    endcase
  end

  assign xfer       = in_valid && in_ready;
  assign count_next = count_reg + 1'b1;

  instmem_loader_pack #(
    .INST_W (INST_W)
  ) u_pack (
    .clk     (clk),
    .rst_n   (rst_n),
    .lo_load (xfer && (state_reg == LO)),
    .hi_load (xfer && (state_reg == HI)),
    .in_data (in_data),
    .hi_bad  (hi_bad),
    .we      (mem_we),
    .wdata   (mem_wdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      addr_reg     <= BASE_ADDR;
      mem_addr_reg <= BASE_ADDR;
      count_reg    <= '0;
      n_reg        <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
`ifdef INSTMEM_LOADER_CSUM_EN
      sum_reg      <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE, DONE, ERR: begin
          if (start) begin
            state_reg    <= LEN;
            addr_reg     <= BASE_ADDR;
            mem_addr_reg <= BASE_ADDR;
            count_reg    <= '0;
            busy_reg     <= 1'b1;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef INSTMEM_LOADER_CSUM_EN
            sum_reg      <= '0;
`endif
          end
        end
        LEN: begin
          if (xfer) begin
            // A zero length byte stands for a full 256-instruction image.
            n_reg     <= (in_data == 8'd0) ? (ADDR_W+1)'(256) : (ADDR_W+1)'(in_data);
            state_reg <= LO;
`ifdef INSTMEM_LOADER_CSUM_EN
            sum_reg   <= in_data;
`endif
          end
        end
        LO: begin
          if (xfer) begin
            state_reg <= HI;
`ifdef INSTMEM_LOADER_CSUM_EN
            sum_reg   <= sum_reg + in_data;
`endif
          end
        end
        HI: begin
          if (xfer) begin
            if (hi_bad) begin
              state_reg <= ERR;
              busy_reg  <= 1'b0;
              err_reg   <= 1'b1;
            end else begin
              // mem_addr tracks the address of the write the pack stage is
              // issuing next cycle; addr_reg already points past it.
              mem_addr_reg <= addr_reg;
              addr_reg     <= addr_reg + 1'b1;
              count_reg    <= count_next;
`ifdef INSTMEM_LOADER_CSUM_EN
              sum_reg      <= sum_reg + in_data;
`endif
              if (count_next == n_reg) begin
`ifdef INSTMEM_LOADER_CSUM_EN
                state_reg <= CSUM;
`else
                state_reg <= DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
`endif
              end else begin
                state_reg <= LO;
              end
            end
          end
        end
`ifdef INSTMEM_LOADER_CSUM_EN
        CSUM: begin
          if (xfer) begin
            busy_reg <= 1'b0;
            if (in_data == sum_reg) begin
              state_reg <= DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ERR;
              err_reg   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr = mem_addr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign err      = err_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_instmem_loader.sv
// Directed bench for instmem_loader. Two instances share clock, reset and
// the byte stream: dut (BASE_ADDR=0) and dut_w (BASE_ADDR=0xFE, used for the
// wrap/N=0 scenario). Only one instance is armed at a time; sel picks whose
// in_ready the byte driver follows.
module tb_instmem_loader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start_w = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       sel = 1'b0;

  logic       in_ready, mem_we, busy, done, err;
  logic [7:0] mem_addr;
  logic [8:0] mem_wdata;
  logic [8:0] count;

  logic       in_ready_w, mem_we_w, busy_w, done_w, err_w;
  logic [7:0] mem_addr_w;
  logic [8:0] mem_wdata_w;
  logic [8:0] count_w;

  logic       rdy;
  int         errors = 0;
  int         checks = 0;
  int         wr_cnt = 0;
  int         wr_cnt_w = 0;
  logic [7:0] csum_acc = 8'h00;

  always #5 clk = ~clk;

  instmem_loader #(.ADDR_W(8), .INST_W(9), .BASE_ADDR(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
    .err(err), .count(count)
  );

  instmem_loader #(.ADDR_W(8), .INST_W(9), .BASE_ADDR(8'hFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready_w), .mem_we(mem_we_w),
    .mem_addr(mem_addr_w), .mem_wdata(mem_wdata_w), .busy(busy_w), .done(done_w),
    .err(err_w), .count(count_w)
  );

  assign rdy = sel ? in_ready_w : in_ready;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_cnt++;
      $display("write dut   addr=%02h data=%03h", mem_addr, mem_wdata);
    end
    if (mem_we_w) begin
      wr_cnt_w++;
      $display("write dut_w addr=%02h data=%03h", mem_addr_w, mem_wdata_w);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation timeout");
  end

  // Offers one byte (after 'gap' idle cycles) and returns on the negedge
  // following the posedge that accepted it.
  task automatic send(input logic [7:0] b, input int gap);
    bit acc;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 50 && !acc; t++) begin
      acc = rdy;
      @(negedge clk);
    end
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_accept byte=%02h accepted=0 required=1", b);
    end
    csum_acc = csum_acc + b;
  endtask

  task automatic pulse_start(input bit which);
    if (which) start_w = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_w = 1'b0;
    csum_acc = 8'h00;
  endtask

  // Sends the trailing checksum when the feature is built in.
  task automatic finish_load(input bit bad_sum);
    logic [7:0] s;
    s = bad_sum ? csum_acc + 8'h01 : csum_acc;
    $display("load stream complete, checksum=%02h", s);
`ifdef INSTMEM_LOADER_CSUM_EN
    send(s, 0);
`endif
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl ready/we/busy=%b%b%b required=000", in_ready, mem_we, busy);
    end
    checks++;
    if (done !== 1'b0 || err !== 1'b0 || count !== 9'd0) begin
      errors++;
      $display("FAIL reset_flags done=%b err=%b count=%0d required 0/0/0", done, err, count);
    end
    checks++;
    if (mem_addr !== 8'h00 || mem_wdata !== 9'h000) begin
      errors++;
      $display("FAIL reset_port addr=%02h wdata=%03h required 00/000", mem_addr, mem_wdata);
    end
    checks++;
    if (mem_addr_w !== 8'hFE || busy_w !== 1'b0 || count_w !== 9'd0) begin
      errors++;
      $display("FAIL reset_base addr=%02h busy=%b count=%0d required FE/0/0", mem_addr_w, busy_w, count_w);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    // in_valid with nothing armed must not start anything.
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset busy=%b ready=%b required 0/0", busy, in_ready);
    end
  endtask

  // Shared by basic and gap scenarios: the 3-instruction image.
  task automatic run_three(input int max_gap, input bit poke_start);
    logic [7:0] lo_t [3];
    logic [7:0] hi_t [3];
    logic [8:0] exp_t [3];
    int base;
    lo_t = '{8'h12, 8'h34, 8'hFF};
    hi_t = '{8'h01, 8'h00, 8'h01};
    exp_t = '{9'h112, 9'h034, 9'h1FF};
    sel = 1'b0;
    base = wr_cnt;
    pulse_start(1'b0);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL armed busy=%b ready=%b required 1/1", busy, in_ready);
    end
    send(8'h03, $urandom_range(0, max_gap));
    if (poke_start) begin
      in_valid = 1'b0;
      pulse_start(1'b0);
      csum_acc = 8'h03;
    end
    for (int i = 0; i < 3; i++) begin
      send(lo_t[i], $urandom_range(0, max_gap));
      send(hi_t[i], $urandom_range(0, max_gap));
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'(i) || mem_wdata !== exp_t[i]) begin
        errors++;
        $display("FAIL write%0d we=%b addr=%02h data=%03h required 1/%02h/%03h",
                 i, mem_we, mem_addr, mem_wdata, 8'(i), exp_t[i]);
      end
    end
    finish_load(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 || count !== 9'd3) begin
      errors++;
      $display("FAIL end_state done=%b busy=%b err=%b count=%0d required 1/0/0/3",
               done, busy, err, count);
    end
    checks++;
    if (wr_cnt - base !== 3) begin
      errors++;
      $display("FAIL write_total got=%0d required=3", wr_cnt - base);
    end
  endtask

  task automatic test_basic;
    run_three(0, 1'b0);
  endtask

  task automatic test_gaps;
    int base;
    run_three(3, 1'b1);
    base = wr_cnt;
    // Bytes offered while DONE must be ignored.
    in_data = 8'h77;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || mem_we !== 1'b0) begin
        errors++;
        $display("FAIL done_ignore ready=%b we=%b required 0/0", in_ready, mem_we);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (count !== 9'd3 || done !== 1'b1 || wr_cnt !== base) begin
      errors++;
      $display("FAIL done_hold count=%0d done=%b new_writes=%0d required 3/1/0",
               count, done, wr_cnt - base);
    end
  endtask

  task automatic test_bad_hi;
    int base;
    sel = 1'b0;
    base = wr_cnt;
    pulse_start(1'b0);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL start_clears_done done=%b required 0", done);
    end
    send(8'h02, 0);
    send(8'h55, 0);
    send(8'h02, 0);
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bad_hi we=%b err=%b busy=%b done=%b ready=%b required 0/1/0/0/0",
               mem_we, err, busy, done, in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt !== base || count !== 9'd0) begin
      errors++;
      $display("FAIL bad_hi_nowrite writes=%0d count=%0d required 0/0", wr_cnt - base, count);
    end
    pulse_start(1'b0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rearm err=%b busy=%b required 0/1", err, busy);
    end
    send(8'h01, 0);
    send(8'hAB, 0);
    send(8'h01, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 9'h1AB) begin
      errors++;
      $display("FAIL rearm_write we=%b addr=%02h data=%03h required 1/00/1AB",
               mem_we, mem_addr, mem_wdata);
    end
    finish_load(1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || count !== 9'd1) begin
      errors++;
      $display("FAIL rearm_done done=%b err=%b count=%0d required 1/0/1", done, err, count);
    end
  endtask

  task automatic test_wrap;
    int base;
    logic [7:0] ea;
    logic [8:0] ed;
    sel = 1'b1;
    base = wr_cnt_w;
    pulse_start(1'b1);
    send(8'h00, 0);
    for (int i = 0; i < 256; i++) begin
      ea = 8'hFE + 8'(i);
      ed = {i[0], 8'(i * 7)};
      send(8'(i * 7), 0);
      send({7'd0, i[0]}, 0);
      checks++;
      if (mem_we_w !== 1'b1 || mem_addr_w !== ea || mem_wdata_w !== ed) begin
        errors++;
        $display("FAIL wrap_write%0d we=%b addr=%02h data=%03h required 1/%02h/%03h",
                 i, mem_we_w, mem_addr_w, mem_wdata_w, ea, ed);
      end
    end
    finish_load(1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (count_w !== 9'd256 || done_w !== 1'b1 || busy_w !== 1'b0 || wr_cnt_w - base !== 256) begin
      errors++;
      $display("FAIL wrap_end count=%0d done=%b busy=%b writes=%0d required 256/1/0/256",
               count_w, done_w, busy_w, wr_cnt_w - base);
    end
    checks++;
    if (busy !== 1'b0 || wr_cnt !== 0 + wr_cnt) begin
      errors++;
      $display("FAIL wrap_other_idle busy=%b required 0", busy);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid;
    int base;
    sel = 1'b0;
    base = wr_cnt;
    pulse_start(1'b0);
    send(8'h03, 0);
    send(8'h12, 0);
    send(8'h01, 0);
    send(8'h34, 0);
    // HI byte of instruction 2 is offered exactly at the reset edge.
    in_data = 8'h01;
    in_valid = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl we=%b busy=%b ready=%b done=%b err=%b required 0/0/0/0/0",
               mem_we, busy, in_ready, done, err);
    end
    checks++;
    if (count !== 9'd0 || mem_addr !== 8'h00 || mem_wdata !== 9'h000) begin
      errors++;
      $display("FAIL midreset_port count=%0d addr=%02h data=%03h required 0/00/000",
               count, mem_addr, mem_wdata);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_after we=%b ready=%b required 0/0", mem_we, in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (wr_cnt - base !== 1) begin
      errors++;
      $display("FAIL midreset_writes got=%0d required=1", wr_cnt - base);
    end
    pulse_start(1'b0);
    send(8'h01, 0);
    send(8'h0F, 0);
    send(8'h01, 0);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 9'h10F) begin
      errors++;
      $display("FAIL midreset_reload we=%b addr=%02h data=%03h required 1/00/10F",
               mem_we, mem_addr, mem_wdata);
    end
    finish_load(1'b0);
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || count !== 9'd1) begin
      errors++;
      $display("FAIL midreset_done done=%b count=%0d required 1/1", done, count);
    end
  endtask

`ifdef INSTMEM_LOADER_CSUM_EN
  task automatic test_csum;
    logic [7:0] cs [2];
    cs = '{8'h12, 8'h13};
    sel = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pulse_start(1'b0);
      send(8'h01, 0);
      send(8'h10, 0);
      send(8'h01, 0);
      checks++;
      if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 9'h110) begin
        errors++;
        $display("FAIL csum_write%0d we=%b addr=%02h data=%03h required 1/00/110",
                 k, mem_we, mem_addr, mem_wdata);
      end
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL csum_wait%0d busy=%b ready=%b done=%b required 1/1/0", k, busy, in_ready, done);
      end
      send(cs[k], 0);
      in_valid = 1'b0;
      checks++;
      if (done !== (k == 0) || err !== (k == 1) || busy !== 1'b0) begin
        errors++;
        $display("FAIL csum_result%0d done=%b err=%b busy=%b required %0d/%0d/0",
                 k, done, err, busy, k == 0, k == 1);
      end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_gaps;
    test_bad_hi;
    test_wrap;
    test_reset_mid;
`ifdef INSTMEM_LOADER_CSUM_EN
    test_csum;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
